// File: rtl/fft_mag_pkg.sv
// Shared types and constants for the FFT magnitude/peak stage.
package fft_mag_pkg;

  localparam logic MODE_MAG = 1'b0;
  localparam logic MODE_SQ  = 1'b1;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

  // Framing sideband carried alongside the data pipeline
  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
    logic mode;
  } side_t;

  // Input-to-output latency: abs stage, square stage, one stage per root bit
  function automatic int unsigned mag_latency(input int unsigned dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/fft_magnitude_peak_sqrt_pipe.sv
// Pipelined non-restoring integer square root, one root bit per stage.
module sqrt_pipe #(
  parameter int unsigned W = 12
) (
  input  logic           clk_50m,
  input  logic           rst_n,
  input  logic [2*W-1:0] radicand_i,
  output logic [W-1:0]   root_o
);

  // Signed partial remainder with headroom for the shifted intermediate
  localparam int unsigned RW = W + 5;

  logic signed [RW-1:0] rem_q   [W];
  logic [2*W-1:0]       rad_q   [W];
  logic [W-1:0]         root_q  [W];
  logic signed [RW-1:0] rem_d   [W];
  logic [2*W-1:0]       rad_d   [W];
  logic [W-1:0]         root_d  [W];

  // Per stage: fold in the next radicand bit pair and resolve one root bit
  always_comb begin
    logic signed [RW-1:0] rem_in;
    logic signed [RW-1:0] rem_sh;
    logic [2*W-1:0]       rad_in;
    logic [W-1:0]         root_in;
    logic [W-1:0]         q_part;
    logic [1:0]           pair;
    for (int s = 0; s < W; s++) begin
      if (s == 0) begin
        rem_in  = '0;
        rad_in  = radicand_i;
        root_in = '0;
      end else begin
        rem_in  = rem_q[s-1];
        rad_in  = rad_q[s-1];
        root_in = root_q[s-1];
      end
      pair   = 2'(rad_in >> (2 * (W - 1 - s)));
      q_part = root_in >> (W - s);
      rem_sh = (rem_in <<< 2) | RW'(pair);
      if (rem_in < 0) begin
        rem_d[s] = rem_sh + RW'({q_part, 2'b11});
      end else begin
        rem_d[s] = rem_sh - RW'({q_part, 2'b01});
      end
      root_d[s] = (rem_d[s] < 0) ? root_in : (root_in | (W'(1) << (W - 1 - s)));
      rad_d[s]  = rad_in;
    end
  end

  // Stage registers
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < W; s++) begin
        rem_q[s]  <= '0;
        rad_q[s]  <= '0;
        root_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < W; s++) begin
        rem_q[s]  <= rem_d[s];
        rad_q[s]  <= rad_d[s];
        root_q[s] <= root_d[s];
      end
    end
  end

  assign root_o = root_q[W-1];

endmodule

// File: rtl/fft_magnitude_peak.sv
// Magnitude (sqrt or squared) of complex FFT bins with per-frame peak tracking.
module fft_magnitude_peak
  import fft_mag_pkg::*;
#(
  parameter int unsigned DW    = 12,
  parameter int unsigned BIN_W = 10
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [DW-1:0]     source_real,
  input  logic [DW-1:0]     source_imag,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic              source_valid,
  output logic [2*DW-1:0]   data_out,
  output logic              data_sop,
  output logic              data_eop,
  output logic              data_valid,
  output logic [2*DW-1:0]   peak_value,
  output logic [BIN_W-1:0]  peak_bin,
  output logic              peak_valid,
  output logic              frame_err
);

  localparam int unsigned L  = mag_latency(DW);
  localparam int unsigned OW = 2 * DW;

  logic              seen_sop_q;
  logic              mode_q;
  logic              acc_valid;
  logic              mode_eff;
  logic [DW-1:0]     abs_re;
  logic [DW-1:0]     abs_im;
  logic [DW-1:0]     abs_re_q;
  logic [DW-1:0]     abs_im_q;
  logic [OW-1:0]     sum_q;
  logic [DW-1:0]     root;
  logic [OW-1:0]     sq_dly_q [DW];
  side_t             side_in;
  side_t             side_q   [L];

  frame_state_e      state_q, state_d;
  logic [BIN_W-1:0]  bin_cnt_q, bin_cnt_d;
  logic [OW-1:0]     run_peak_q, run_peak_d;
  logic [BIN_W-1:0]  run_bin_q, run_bin_d;
  logic [OW-1:0]     peak_value_q, peak_value_d;
  logic [BIN_W-1:0]  peak_bin_q, peak_bin_d;
  logic              peak_valid_q, peak_valid_d;
  logic              frame_err_q, frame_err_d;

  // Nothing is accepted after reset until a sop arrives
  assign acc_valid = source_valid & (seen_sop_q | source_sop);
  assign mode_eff  = (source_valid & source_sop) ? mode : mode_q;
  assign abs_re    = source_real[DW-1] ? DW'(~source_real + 1'b1) : source_real;
  assign abs_im    = source_imag[DW-1] ? DW'(~source_imag + 1'b1) : source_imag;

  // Mode is latched per frame on sop; sop-seen flag arms the input
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      seen_sop_q <= 1'b0;
      mode_q     <= MODE_MAG;
    end else if (source_valid && source_sop) begin
      seen_sop_q <= 1'b1;
      mode_q     <= mode;
    end
  end

  // Stage 1 absolute value, stage 2 sum of squares
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      abs_re_q <= '0;
      abs_im_q <= '0;
      sum_q    <= '0;
    end else begin
      abs_re_q <= abs_re;
      abs_im_q <= abs_im;
      sum_q    <= OW'(abs_re_q) * OW'(abs_re_q) + OW'(abs_im_q) * OW'(abs_im_q);
    end
  end

  sqrt_pipe #(.W(DW)) u_sqrt (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .radicand_i (sum_q),
    .root_o     (root)
  );

  // Sideband entering the delay line; invalid cycles carry no framing
  always_comb begin
    side_in       = '0;
    side_in.valid = acc_valid;
    side_in.sop   = acc_valid & source_sop;
    side_in.eop   = acc_valid & source_eop;
    side_in.mode  = mode_eff;
  end

  // Squared-magnitude and sideband delay lines matching the root latency
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DW); i++) sq_dly_q[i] <= '0;
      for (int i = 0; i < int'(L); i++)  side_q[i]   <= '0;
    end else begin
      sq_dly_q[0] <= sum_q;
      for (int i = 1; i < int'(DW); i++) sq_dly_q[i] <= sq_dly_q[i-1];
      side_q[0] <= side_in;
      for (int i = 1; i < int'(L); i++)  side_q[i]   <= side_q[i-1];
    end
  end

  assign data_valid = side_q[L-1].valid;
  assign data_sop   = side_q[L-1].sop;
  assign data_eop   = side_q[L-1].eop;

  // Output select between two same-stage registers
  always_comb begin
    data_out = OW'(root);
    case (side_q[L-1].mode)
      MODE_MAG: data_out = OW'(root);
      MODE_SQ:  data_out = sq_dly_q[DW-1];
    endcase
  end

  // Peak tracker state register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bin_cnt_q    <= '0;
      run_peak_q   <= '0;
      run_bin_q    <= '0;
      peak_value_q <= '0;
      peak_bin_q   <= '0;
      peak_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      run_peak_q   <= run_peak_d;
      run_bin_q    <= run_bin_d;
      peak_value_q <= peak_value_d;
      peak_bin_q   <= peak_bin_d;
      peak_valid_q <= peak_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Peak tracker next state: first-occurrence max, publish after eop
  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    run_peak_d   = run_peak_q;
    run_bin_d    = run_bin_q;
    peak_value_d = peak_value_q;
    peak_bin_d   = peak_bin_q;
    peak_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (data_valid) begin
      if (data_sop) begin
        frame_err_d = (state_q == IN_FRAME);
        bin_cnt_d   = '0;
        run_peak_d  = data_out;
        run_bin_d   = '0;
        if (data_eop) begin
          peak_value_d = data_out;
          peak_bin_d   = '0;
          peak_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = IN_FRAME;
        end
      end else if (state_q == IN_FRAME) begin
        bin_cnt_d = bin_cnt_q + BIN_W'(1);
        if (data_out > run_peak_q) begin
          run_peak_d = data_out;
          run_bin_d  = bin_cnt_d;
        end
        if (data_eop) begin
          peak_value_d = run_peak_d;
          peak_bin_d   = run_bin_d;
          peak_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end else if (data_eop) begin
        frame_err_d = 1'b1;
      end
    end
  end

  assign peak_value = peak_value_q;
  assign peak_bin   = peak_bin_q;
  assign peak_valid = peak_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_magnitude_peak.sv
// Randomized self-checking bench for fft_magnitude_peak against a frame-level model.
module tb_fft_magnitude_peak;

  localparam int DW    = 12;
  localparam int BIN_W = 10;
  localparam int L     = DW + 2;
  localparam int OW    = 2 * DW;
  localparam int NC    = 16384;

  logic              clk_50m;
  logic              rst_n;
  logic              mode;
  logic [DW-1:0]     source_real;
  logic [DW-1:0]     source_imag;
  logic              source_sop;
  logic              source_eop;
  logic              source_valid;
  logic [OW-1:0]     data_out;
  logic              data_sop;
  logic              data_eop;
  logic              data_valid;
  logic [OW-1:0]     peak_value;
  logic [BIN_W-1:0]  peak_bin;
  logic              peak_valid;
  logic              frame_err;

  fft_magnitude_peak #(.DW(DW), .BIN_W(BIN_W)) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .mode         (mode),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_valid (source_valid),
    .data_out     (data_out),
    .data_sop     (data_sop),
    .data_eop     (data_eop),
    .data_valid   (data_valid),
    .peak_value   (peak_value),
    .peak_bin     (peak_bin),
    .peak_valid   (peak_valid),
    .frame_err    (frame_err)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  // Expected outputs indexed by the negedge on which they must be seen
  bit             ev    [NC];
  bit             es    [NC];
  bit             ee    [NC];
  bit [OW-1:0]    ed    [NC];
  bit             epv   [NC];
  bit [OW-1:0]    epval [NC];
  bit [BIN_W-1:0] epbin [NC];
  bit             eerr  [NC];

  int             checks;
  int             errors;
  int             cyc;
  bit             seen;
  bit             fmode;
  bit             in_frame;
  longint         fq [$];
  bit [OW-1:0]    hold_v;
  bit [BIN_W-1:0] hold_b;
  bit             prev_rst;
  int             fre [$];
  int             fim [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint s);
    longint r = 0;
    for (int b = 15; b >= 0; b--) begin
      longint t = r | (longint'(1) << b);
      if (t * t <= s) r = t;
    end
    return r;
  endfunction

  // Frame-level reference: magnitude per bin, first-occurrence max per frame
  task automatic model_bin(input bit sop, input bit eop, input bit m, input int re, input int im);
    longint ar, ai, s, mag, best;
    int     bi;
    if (!(seen || sop)) return;
    if (sop) begin
      seen  = 1'b1;
      fmode = m;
    end
    ar  = (re < 0) ? -re : re;
    ai  = (im < 0) ? -im : im;
    s   = ar * ar + ai * ai;
    mag = fmode ? s : isqrt(s);
    ev[cyc+L] = 1'b1;
    es[cyc+L] = sop;
    ee[cyc+L] = eop;
    ed[cyc+L] = OW'(mag);
    if (sop) begin
      if (in_frame) eerr[cyc+L+1] = 1'b1;
      fq.delete();
      fq.push_back(mag);
      in_frame = 1'b1;
    end else if (in_frame) begin
      fq.push_back(mag);
    end else if (eop) begin
      eerr[cyc+L+1] = 1'b1;
    end
    if (eop && in_frame) begin
      best = fq[0];
      bi   = 0;
      foreach (fq[i]) if (fq[i] > best) begin best = fq[i]; bi = i; end
      epv[cyc+L+1]   = 1'b1;
      epval[cyc+L+1] = OW'(best);
      epbin[cyc+L+1] = BIN_W'(bi);
      in_frame = 1'b0;
    end
  endtask

  // One clock: check this cycle's outputs, then drive the next input
  task automatic step(input bit rst, input bit v, input bit sop, input bit eop,
                      input bit m, input int re, input int im);
    @(negedge clk_50m);
    if (cyc + L + 2 >= NC) begin
      $display("FAIL cycle_budget cyc=%0d got=overflow exp=<%0d", cyc, NC);
      $fatal(1, "cycle budget exceeded");
    end
    if (epv[cyc]) begin
      hold_v = epval[cyc];
      hold_b = epbin[cyc];
    end
    check_eq("data_valid", data_valid, ev[cyc]);
    check_eq("data_sop",   data_sop,   es[cyc]);
    check_eq("data_eop",   data_eop,   ee[cyc]);
    if (ev[cyc]) check_eq("data_out", data_out, ed[cyc]);
    if (prev_rst) check_eq("data_out_rst", data_out, 0);
    check_eq("peak_valid", peak_valid, epv[cyc]);
    check_eq("peak_value", peak_value, hold_v);
    check_eq("peak_bin",   peak_bin,   hold_b);
    check_eq("frame_err",  frame_err,  eerr[cyc]);
    prev_rst = rst;
    if (rst) begin
      rst_n        = 1'b0;
      source_valid = 1'b0;
      source_sop   = 1'b0;
      source_eop   = 1'b0;
      mode         = 1'b0;
      source_real  = '0;
      source_imag  = '0;
      seen = 1'b0; fmode = 1'b0; in_frame = 1'b0; fq.delete();
      hold_v = '0; hold_b = '0;
      for (int i = cyc + 1; i < cyc + L + 3; i++) begin
        ev[i] = 0; es[i] = 0; ee[i] = 0; ed[i] = '0;
        epv[i] = 0; epval[i] = '0; epbin[i] = '0; eerr[i] = 0;
      end
    end else begin
      rst_n        = 1'b1;
      source_valid = v;
      source_sop   = sop;
      source_eop   = eop;
      mode         = m;
      source_real  = DW'(re);
      source_imag  = DW'(im);
      if (v) model_bin(sop, eop, m, re, im);
    end
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
  endtask

  task automatic single(input bit m, input int re, input int im);
    step(0, 1, 1, 1, m, re, im);
    idle(L + 2);
  endtask

  // Sends fre/fim[0..nsend-1]; eop on the last one unless aborted
  task automatic send_frame(input bit m, input int max_gap, input int toggle_at,
                            input bit abort, input int nsend);
    for (int i = 0; i < nsend; i++) begin
      bit mi = (i >= toggle_at) ? ~m : m;
      step(0, 1, (i == 0), (!abort && i == nsend - 1), mi, fre[i], fim[i]);
      if (max_gap > 0 && i < nsend - 1) idle(int'($urandom_range(1, max_gap)));
    end
  endtask

  task automatic load_rand(input int n);
    fre.delete(); fim.delete();
    for (int i = 0; i < n; i++) begin
      fre.push_back(int'($urandom_range(0, 4095)) - 2048);
      fim.push_back(int'($urandom_range(0, 4095)) - 2048);
    end
  endtask

  initial begin
    int mags [8] = '{1, 7, 3, 9, 2, 9, 0, 4};
    checks = 0; errors = 0; cyc = 0;
    seen = 0; fmode = 0; in_frame = 0; hold_v = '0; hold_b = '0; prev_rst = 0;
    rst_n = 1'b0; mode = 1'b0; source_real = '0; source_imag = '0;
    source_sop = 1'b0; source_eop = 1'b0; source_valid = 1'b0;

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    // Stray bins before any sop must be ignored
    step(0, 1, 0, 1, 0, 5, 5);
    step(0, 1, 0, 0, 1, 7, 1);
    idle(L + 2);

    single(0, 3, 4);
    single(1, 3, 4);
    single(1, -2048, -2048);
    single(0, -2048, -2048);
    single(0, 2047, -2048);

    fre.delete(); fim.delete();
    foreach (mags[i]) begin fre.push_back(mags[i]); fim.push_back(0); end
    send_frame(0, 0, 99, 0, 8);
    idle(L + 3);
    send_frame(0, 3, 99, 0, 8);
    idle(L + 3);

    // Mode toggled mid-frame, then the following frame in the new mode
    load_rand(8);
    send_frame(0, 0, 4, 0, 8);
    load_rand(6);
    send_frame(1, 1, 99, 0, 6);
    idle(L + 3);

    // Restart at bin 5 of an open frame
    load_rand(5);
    send_frame(1, 0, 99, 1, 5);
    fre.delete(); fim.delete();
    foreach (mags[i]) begin fre.push_back(-mags[i]); fim.push_back(0); end
    send_frame(0, 0, 99, 0, 8);
    idle(L + 3);

    // Reset in the middle of a frame
    load_rand(6);
    send_frame(0, 0, 99, 1, 6);
    idle(4);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(L + 4);

    // Randomized frames with gaps, aborts and stray eops
    for (int f = 0; f < 50; f++) begin
      int r = int'($urandom_range(0, 9));
      int n = int'($urandom_range(1, 20));
      if (r == 0) step(0, 1, 0, 1, 1'($urandom), 100, -100);
      load_rand(n);
      send_frame(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 24)),
                 (r == 1), n);
      idle(int'($urandom_range(0, 3)));
    end
    idle(L + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
